// File: rtl/updi_txn_ctrl.sv
// UPDI transaction sequencer in front of uart_fifo: sends a command burst, checks the
// single-wire echo of every byte, then hands the response bytes to the requester.
module updi_txn_ctrl #(
    parameter int MAX_TX         = 16,
    parameter int MAX_RX         = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(MAX_TX+1)-1:0]   cmd_tx_len,
    input  logic [$clog2(MAX_RX+1)-1:0]   cmd_rx_len,
    input  logic [7:0]                    txb_data,
    input  logic                          txb_valid,
    output logic                          txb_ready,
    output logic [7:0]                    rsp_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          done,
    output logic [2:0]                    status,
    output logic [7:0]                    uf_tx_data,
    output logic                          uf_tx_wr_en,
    input  logic                          uf_tx_full,
    input  logic [7:0]                    uf_rx_data,
    output logic                          uf_rx_rd_en,
    input  logic                          uf_rx_empty,
    input  logic                          uf_rx_error
);

    localparam int TXL_W = $clog2(MAX_TX + 1);
    localparam int RXL_W = $clog2(MAX_RX + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SH_W  = (MAX_TX > 1) ? $clog2(MAX_TX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        RECV   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [TXL_W-1:0]   tx_len, sent, echoed;
    logic [RXL_W-1:0]   rx_len, rcvd;
    logic [TMR_W-1:0]   timer;
    logic [2:0]         sts;
    logic               rd_pend;
    logic [7:0]         shadow [0:MAX_TX-1];

    logic               active, tmo, tx_fire, rx_rd, rsp_acc, accept;

    function automatic logic [TXL_W-1:0] clamp_tx(input logic [TXL_W-1:0] n);
        if (n == '0)
            return TXL_W'(1);
        else if (n > TXL_W'(MAX_TX))
            return TXL_W'(MAX_TX);
        else
            return n;
    endfunction

    function automatic logic [RXL_W-1:0] clamp_rx(input logic [RXL_W-1:0] n);
        if (n > RXL_W'(MAX_RX))
            return RXL_W'(MAX_RX);
        else
            return n;
    endfunction

    assign cmd_ready   = (state == IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign active      = (state == XFER) || (state == RECV);
    assign tmo         = active && (timer == TMR_W'(TIMEOUT_CYCLES));
    assign rsp_acc     = rsp_valid && rsp_ready;
    assign txb_ready   = tx_fire;
    assign uf_tx_wr_en = tx_fire;
    assign uf_tx_data  = tx_fire ? txb_data : 8'h00;
    assign uf_rx_rd_en = rx_rd;
    assign done        = (state == FINISH);
    assign status      = done ? sts : 3'b000;

    // Reads never run ahead of writes in XFER, so every echo has a shadow entry to compare against.
    always_comb begin
        state_nxt = state;
        rx_rd     = 1'b0;
        tx_fire   = (state == XFER) && txb_valid && !uf_tx_full && (sent < tx_len);
        if (state == XFER)
            rx_rd = !uf_rx_empty && !rd_pend && (echoed < sent) && !tmo;
        else if (state == RECV)
            rx_rd = !uf_rx_empty && !rd_pend && !rsp_valid && (rcvd < rx_len) && !tmo;

        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = XFER;
            end
            XFER: begin
                if (tmo)
                    state_nxt = FINISH;
                else if (echoed == tx_len)
                    state_nxt = (rx_len != '0) ? RECV : FINISH;
            end
            RECV: begin
                if (tmo)
                    state_nxt = FINISH;
                else if (rsp_acc && ((rcvd + 1'b1) == rx_len))
                    state_nxt = FINISH;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_len    <= '0;
            rx_len    <= '0;
            sent      <= '0;
            echoed    <= '0;
            rcvd      <= '0;
            timer     <= '0;
            sts       <= '0;
            rd_pend   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            state   <= state_nxt;
            rd_pend <= rx_rd;

            if (accept) begin
                tx_len <= clamp_tx(cmd_tx_len);
                rx_len <= clamp_rx(cmd_rx_len);
                sent   <= '0;
                echoed <= '0;
                rcvd   <= '0;
                sts    <= '0;
                timer  <= '0;
            end

            if (tx_fire) sent <= sent + 1'b1;

            if ((state == XFER) && rd_pend) begin
                if (uf_rx_data != shadow[echoed[SH_W-1:0]]) sts[1] <= 1'b1;
                echoed <= echoed + 1'b1;
            end

            if ((state == RECV) && rd_pend) begin
                rsp_data  <= uf_rx_data;
                rsp_valid <= 1'b1;
            end else if (rsp_acc) begin
                rsp_valid <= 1'b0;
                rcvd      <= rcvd + 1'b1;
            end

            if (active && uf_rx_error) sts[2] <= 1'b1;

            // A requester stalling on rsp_ready is not a dead link, so it holds the timer at zero.
            if (active) begin
                if (rx_rd || (rsp_valid && !rsp_ready))
                    timer <= '0;
                else if (!tmo)
                    timer <= timer + 1'b1;
            end

            if (tmo) begin
                sts[0]    <= 1'b1;
                rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_fire) shadow[sent[SH_W-1:0]] <= txb_data;
    end

endmodule

// File: tb/tb_updi_txn_ctrl.sv
// Bench for updi_txn_ctrl: behavioural uart_fifo with loopback echo and canned replies,
// a table of whole transactions plus hand-written stall, timeout and reset sequences.
module tb_updi_txn_ctrl;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_tx_len = '0;
    logic [4:0] cmd_rx_len = '0;
    logic [7:0] txb_data;
    logic       txb_valid;
    logic       txb_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       done;
    logic [2:0] status;
    logic [7:0] uf_tx_data;
    logic       uf_tx_wr_en;
    logic       uf_tx_full = 1'b0;
    logic [7:0] uf_rx_data = 8'h00;
    logic       uf_rx_rd_en;
    logic       uf_rx_empty = 1'b1;
    logic       uf_rx_error = 1'b0;

    always #5 clk = ~clk;

    updi_txn_ctrl #(.MAX_TX(16), .MAX_RX(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tx_len(cmd_tx_len), .cmd_rx_len(cmd_rx_len),
        .txb_data(txb_data), .txb_valid(txb_valid), .txb_ready(txb_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .done(done), .status(status),
        .uf_tx_data(uf_tx_data), .uf_tx_wr_en(uf_tx_wr_en), .uf_tx_full(uf_tx_full),
        .uf_rx_data(uf_rx_data), .uf_rx_rd_en(uf_rx_rd_en), .uf_rx_empty(uf_rx_empty),
        .uf_rx_error(uf_rx_error)
    );

    typedef struct packed {
        logic [4:0]   tx_len;
        logic [4:0]   rx_len;
        logic [127:0] tx;
        logic [127:0] xr;
        logic [127:0] rp;
        logic [4:0]   n_rp;
        logic         err;
        logic [4:0]   exp_nw;
        logic [4:0]   exp_nr;
        logic [2:0]   exp_st;
    } vec_t;

    // uf_fifo / source model state
    logic [7:0]   rxq [$];
    int           wcnt = 0;
    int           echo_n = 0;
    int           n_rp = 0;
    logic [127:0] xr_v = '0;
    logic [127:0] rp_v = '0;
    logic         flush = 1'b0;
    logic [7:0]   src_mem [16];
    logic         src_en = 1'b0;
    logic [4:0]   src_idx = '0;
    logic         s_wr = 1'b0, s_rd = 1'b0, s_txf = 1'b0;
    logic [7:0]   s_wd = 8'h00;

    // monitors
    logic [7:0]   wr_log [$];
    logic [7:0]   got [$];
    int           n_rd = 0, n_done = 0, last_rd = 0, done_cyc = 0, cyc = 0;

    int           total = 0, bad = 0;
    int           b_w, b_g;

    assign txb_data  = src_mem[src_idx[3:0]];
    assign txb_valid = src_en && (src_idx < 5'd16);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        s_wr  = uf_tx_wr_en;
        s_wd  = uf_tx_data;
        s_rd  = uf_rx_rd_en;
        s_txf = txb_valid && txb_ready;
        if (uf_tx_wr_en) wr_log.push_back(uf_tx_data);
        if (rsp_valid && rsp_ready) got.push_back(rsp_data);
        if (uf_rx_rd_en) begin n_rd++; last_rd = cyc; end
        if (done) begin n_done++; done_cyc = cyc; end
    end

    always @(posedge clk) begin
        if (flush) begin
            rxq.delete();
            wcnt = 0;
            src_idx <= '0;
        end else begin
            if (s_rd && rxq.size() > 0) uf_rx_data <= rxq.pop_front();
            if (s_wr) begin
                if (wcnt < 16) rxq.push_back(s_wd ^ xr_v[wcnt*8 +: 8]);
                wcnt++;
                if (wcnt == echo_n)
                    for (int i = 0; i < n_rp; i++) rxq.push_back(rp_v[i*8 +: 8]);
            end
            if (s_txf) src_idx <= src_idx + 5'd1;
        end
        uf_rx_empty <= (rxq.size() == 0);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic vec_t mk(input int txl, input int rxl, input logic [127:0] tx,
                                input logic [127:0] xr, input logic [127:0] rp, input int nrp,
                                input logic err, input int nw, input int nr, input logic [2:0] st);
        vec_t v;
        v.tx_len = 5'(txl);
        v.rx_len = 5'(rxl);
        v.tx     = tx;
        v.xr     = xr;
        v.rp     = rp;
        v.n_rp   = 5'(nrp);
        v.err    = err;
        v.exp_nw = 5'(nw);
        v.exp_nr = 5'(nr);
        v.exp_st = st;
        return v;
    endfunction

    task automatic prep(input vec_t v);
        @(posedge clk); #1;
        flush  = 1'b1;
        src_en = 1'b0;
        echo_n = int'(v.exp_nw);
        xr_v   = v.xr;
        rp_v   = v.rp;
        n_rp   = int'(v.n_rp);
        for (int i = 0; i < 16; i++) src_mem[i] = v.tx[i*8 +: 8];
        @(posedge clk); #1;
        flush  = 1'b0;
        src_en = 1'b1;
    endtask

    task automatic issue(input vec_t v);
        b_w = wr_log.size();
        b_g = got.size();
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_tx_len = v.tx_len;
        cmd_rx_len = v.rx_len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (v.err) begin
            uf_rx_error = 1'b1;
            @(posedge clk); #1;
            uf_rx_error = 1'b0;
        end
    endtask

    task automatic finish_check(input string tag, input vec_t v);
        logic [2:0] st = 3'b000;
        bit         seen = 1'b0;
        int         a;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin st = status; seen = 1'b1; break; end
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        @(negedge clk);
        check({tag, "_done_1cyc"}, int'(done), 0);
        #1;
        check({tag, "_status"}, int'(st), int'(v.exp_st));
        check({tag, "_nwr"}, wr_log.size() - b_w, int'(v.exp_nw));
        for (int i = 0; i < int'(v.exp_nw); i++) begin
            a = (b_w + i < wr_log.size()) ? int'(wr_log[b_w + i]) : -1;
            check($sformatf("%s_wr%0d", tag, i), a, int'(v.tx[i*8 +: 8]));
        end
        check({tag, "_nrsp"}, got.size() - b_g, int'(v.exp_nr));
        for (int i = 0; i < int'(v.exp_nr); i++) begin
            a = (b_g + i < got.size()) ? int'(got[b_g + i]) : -1;
            check($sformatf("%s_rsp%0d", tag, i), a, int'(v.rp[i*8 +: 8]));
        end
        if (v.exp_st[0]) check_rng({tag, "_tmo_lat"}, done_cyc - last_rd, TMO - 5, TMO + 10);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        prep(v);
        issue(v);
        finish_check(tag, v);
    endtask

    task automatic wait_rsp_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        check({tag, "_rsp_valid_seen"}, int'(seen), 1);
    endtask

    initial begin
        vec_t vt [6];
        vec_t v;
        int   k, hits, whits, d0, r0, bd;
        bit   seen;

        vt[0] = mk(2, 1,  128'hC455,   '0,        128'h30, 1, 1'b0, 2, 1,  3'b000);
        vt[1] = mk(3, 1,  128'h010455, 128'h4000, 128'hA5, 1, 1'b0, 3, 1,  3'b010);
        vt[2] = mk(0, 0,  128'h9C,     '0,        '0,      0, 1'b0, 1, 0,  3'b000);
        vt[3] = mk(1, 20, 128'hAA,     '0, 128'h1F1E1D1C1B1A19181716151413121110, 16, 1'b0, 1, 16, 3'b000);
        vt[4] = mk(2, 2,  128'h3412,   '0,        128'h7856, 2, 1'b1, 2, 2, 3'b100);
        vt[5] = mk(1, 2,  128'h3C,     '0,        128'h77, 1, 1'b0, 1, 1,  3'b001);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_txb_ready", int'(txb_ready), 0);
        check("rst_wr_en", int'(uf_tx_wr_en), 0);
        check("rst_rd_en", int'(uf_rx_rd_en), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_status", int'(status), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec($sformatf("v%0d", i), vt[i]);

        // TX FIFO full for 20 cycles in the middle of a 16-byte burst
        v = mk(16, 0, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, '0, '0, 0, 1'b0, 16, 0, 3'b000);
        prep(v);
        issue(v);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (wr_log.size() - b_w >= 5) begin seen = 1'b1; break; end
        end
        check("full_pre_writes", int'(seen), 1);
        @(posedge clk); #1;
        uf_tx_full = 1'b1;
        hits = 0;
        whits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txb_ready) hits++;
            if (uf_tx_wr_en) whits++;
        end
        check("full_txb_ready", hits, 0);
        check("full_wr_en", whits, 0);
        @(posedge clk); #1;
        uf_tx_full = 1'b0;
        finish_check("full", v);

        // requester stalls 50 cycles on the first response byte
        v = mk(1, 4, 128'h5A, '0, 128'hC4C3C2C1, 4, 1'b0, 1, 4, 3'b000);
        rsp_ready = 1'b0;
        prep(v);
        issue(v);
        wait_rsp_valid("stall");
        #1;
        d0 = int'(rsp_data);
        r0 = n_rd;
        check("stall_first", d0, 8'hC1);
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rsp_valid || int'(rsp_data) != d0) hits++;
        end
        #1;
        check("stall_hold", hits, 0);
        check("stall_no_extra_rd", n_rd - r0, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        finish_check("stall", v);

        // asynchronous reset while in the response phase
        v = mk(1, 3, 128'h11, '0, 128'h333231, 3, 1'b0, 1, 3, 3'b000);
        rsp_ready = 1'b0;
        prep(v);
        issue(v);
        wait_rsp_valid("arst");
        #1;
        bd = n_done;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("arst_cmd_ready", int'(cmd_ready), 1);
        check("arst_rsp_valid", int'(rsp_valid), 0);
        check("arst_rd_en", int'(uf_rx_rd_en), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        rsp_ready = 1'b1;
        k = 0;
        repeat (20) @(negedge clk);
        #1;
        k = n_done - bd;
        check("arst_no_done", k, 0);
        run_vec("after_rst", vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
